eeprom_req_arb: RTL and testbench

Two-port request arbiter and sequencer in front of the `EEPROM_WR` parallel-to-I2C converter. It accepts byte read and write requests from two independent requesters, grants them round-robin, and drives the `WR`/`RD` strobe, `ADDR` and data bus of `EEPROM_WR` exactly as an MCU would. It waits for the converter's `ACK`, returns read data and a completion pulse to the winning requester, then releases the converter for the next request. It sits between the system masters (port 0 = MCU, port 1 = config loader) and `EEPROM_WR`.

---
 rtl/eeprom_req_arb.sv | 186 ++++++++++++++++++
 tb/tb_eeprom_req_arb.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/eeprom_req_arb.sv
// Two-port round-robin request arbiter and strobe sequencer in front of the EEPROM_WR converter.
// Optional ACK watchdog with ERR reporting is built when EEPROM_ARB_TIMEOUT_EN is defined.
module eeprom_req_arb #(
   parameter int unsigned GAP_CYCLES     = 4,
   parameter logic [11:0] TIMEOUT_CYCLES = 12'd4095
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        REQ0,
   input  logic        REQ1,
   input  logic        WE0,
   input  logic        WE1,
   input  logic [10:0] ADDR0,
   input  logic [10:0] ADDR1,
   input  logic [7:0]  WDATA0,
   input  logic [7:0]  WDATA1,
   output logic        GNT0,
   output logic        GNT1,
   output logic        DONE0,
   output logic        DONE1,
   output logic        ERR0,
   output logic        ERR1,
   output logic [7:0]  RDATA0,
   output logic [7:0]  RDATA1,
   output logic        BUSY,
   output logic        WR,
   output logic        RD,
   output logic [10:0] ADDR,
   output logic [7:0]  DOUT,
   output logic        DOE,
   input  logic [7:0]  DIN,
   input  logic        ACK
);

   localparam logic [2:0] IDLE     = 3'd0;
   localparam logic [2:0] GAP      = 3'd1;
   localparam logic [2:0] STROBE   = 3'd2;
   localparam logic [2:0] WAIT_ACK = 3'd3;
   localparam logic [2:0] DONE     = 3'd4;

   localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

   logic [2:0]  state_q, state_d;
   logic        ptr_q, ptr_d;
   logic        port_q, port_d;
   logic        we_q, we_d;
   logic [10:0] addr_q, addr_d;
   logic [7:0]  wdata_q, wdata_d;
   logic [3:0]  gap_q, gap_d;
   logic [1:0]  gnt_q, gnt_d;
   logic [7:0]  rdata0_q, rdata0_d;
   logic [7:0]  rdata1_q, rdata1_d;
   logic        ack_q;
   logic        winner;
   logic        ackRise;
`ifdef EEPROM_ARB_TIMEOUT_EN
   logic [11:0] wd_q, wd_d;
   logic        err_q, err_d;
`endif

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      port_d   = port_q;
      we_d     = we_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      gap_d    = gap_q;
      gnt_d    = 2'b00;
      rdata0_d = rdata0_q;
      rdata1_d = rdata1_q;
      winner   = 1'b0;
      ackRise  = ACK & ~ack_q;
`ifdef EEPROM_ARB_TIMEOUT_EN
      wd_d     = wd_q;
      err_d    = err_q;
`endif
      case (state_q)
         IDLE: begin
            if (REQ0 | REQ1) begin
               // On a tie the port not served last wins; otherwise the sole requester.
               winner  = (REQ0 & REQ1) ? ~ptr_q : REQ1;
               port_d  = winner;
               ptr_d   = winner;
               we_d    = winner ? WE1 : WE0;
               addr_d  = winner ? ADDR1 : ADDR0;
               wdata_d = winner ? WDATA1 : WDATA0;
               gnt_d   = winner ? 2'b10 : 2'b01;
               gap_d   = 4'd0;
`ifdef EEPROM_ARB_TIMEOUT_EN
               err_d   = 1'b0;
`endif
               state_d = GAP;
            end
         end
         GAP: begin
            if (gap_q == GAP_LAST) state_d = STROBE;
            else                   gap_d   = gap_q + 4'd1;
         end
         STROBE: begin
`ifdef EEPROM_ARB_TIMEOUT_EN
            // Watchdog holds cycles elapsed since the strobe, so the first WAIT_ACK cycle is 1.
            wd_d    = 12'd1;
`endif
            state_d = WAIT_ACK;
         end
         WAIT_ACK: begin
            if (ackRise) begin
               if (!we_q) begin
                  if (port_q) rdata1_d = DIN;
                  else        rdata0_d = DIN;
               end
               state_d = DONE;
            end
`ifdef EEPROM_ARB_TIMEOUT_EN
            else if (wd_q == TIMEOUT_CYCLES - 12'd1) begin
               err_d   = 1'b1;
               state_d = DONE;
            end else begin
               wd_d = wd_q + 12'd1;
            end
`endif
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // All state, latches and the ACK history register; reset aborts any transaction.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q  <= IDLE;
         ptr_q    <= 1'b1;
         port_q   <= 1'b0;
         we_q     <= 1'b0;
         addr_q   <= 11'd0;
         wdata_q  <= 8'd0;
         gap_q    <= 4'd0;
         gnt_q    <= 2'b00;
         rdata0_q <= 8'd0;
         rdata1_q <= 8'd0;
         ack_q    <= 1'b0;
`ifdef EEPROM_ARB_TIMEOUT_EN
         wd_q     <= 12'd0;
         err_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         port_q   <= port_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         gap_q    <= gap_d;
         gnt_q    <= gnt_d;
         rdata0_q <= rdata0_d;
         rdata1_q <= rdata1_d;
         ack_q    <= ACK;
`ifdef EEPROM_ARB_TIMEOUT_EN
         wd_q     <= wd_d;
         err_q    <= err_d;
`endif
      end
   end

   assign BUSY   = (state_q != IDLE);
   assign WR     = (state_q == STROBE) & we_q;
   assign RD     = (state_q == STROBE) & ~we_q;
   assign ADDR   = addr_q;
   assign DOUT   = wdata_q;
   assign DOE    = we_q & BUSY;
   assign GNT0   = gnt_q[0];
   assign GNT1   = gnt_q[1];
   assign DONE0  = (state_q == DONE) & ~port_q;
   assign DONE1  = (state_q == DONE) & port_q;
   assign RDATA0 = rdata0_q;
   assign RDATA1 = rdata1_q;
`ifdef EEPROM_ARB_TIMEOUT_EN
   assign ERR0   = DONE0 & err_q;
   assign ERR1   = DONE1 & err_q;
`else
   assign ERR0   = 1'b0;
   assign ERR1   = 1'b0;
`endif

endmodule

// File: tb/tb_eeprom_req_arb.sv
// Randomized self-checking bench for eeprom_req_arb against a transaction-level model.
// Honours EEPROM_ARB_TIMEOUT_EN to pick the watchdog or the hang scenario.
module tb_eeprom_req_arb;

   localparam int GAP = 4;
   localparam int TMO = 16;

   logic        CLK = 1'b0;
   logic        RESET;
   logic        ACK;
   logic [7:0]  DIN;
   logic        GNT0, GNT1, DONE0, DONE1, ERR0, ERR1, BUSY, WR, RD, DOE;
   logic [7:0]  RDATA0, RDATA1, DOUT;
   logic [10:0] ADDR;

   logic [1:0]  reqM;
   logic [1:0]  weM;
   logic [10:0] addrM [2];
   logic [7:0]  wdataM [2];
   logic [7:0]  rdataM [2];
   logic        ptrM;
   logic [10:0] lastAddr;
   logic        lastGrant;
   logic [3:0]  order;

   int checks = 0;
   int errors = 0;

   always #5 CLK = ~CLK;

   eeprom_req_arb #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(12'(TMO))) dut (
      .CLK(CLK), .RESET(RESET),
      .REQ0(reqM[0]), .REQ1(reqM[1]), .WE0(weM[0]), .WE1(weM[1]),
      .ADDR0(addrM[0]), .ADDR1(addrM[1]), .WDATA0(wdataM[0]), .WDATA1(wdataM[1]),
      .GNT0(GNT0), .GNT1(GNT1), .DONE0(DONE0), .DONE1(DONE1), .ERR0(ERR0), .ERR1(ERR1),
      .RDATA0(RDATA0), .RDATA1(RDATA1), .BUSY(BUSY), .WR(WR), .RD(RD),
      .ADDR(ADDR), .DOUT(DOUT), .DOE(DOE), .DIN(DIN), .ACK(ACK)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic applyStimulus(input int p, input logic we, input logic [10:0] a, input logic [7:0] d);
      reqM[p]   = 1'b1;
      weM[p]    = we;
      addrM[p]  = a;
      wdataM[p] = d;
   endtask

   task automatic randomRequest(input int p);
      applyStimulus(p, 1'($urandom_range(0, 1)), 11'($urandom), 8'($urandom));
   endtask

   task automatic resetModel();
      ptrM      = 1'b1;
      rdataM[0] = 8'd0;
      rdataM[1] = 8'd0;
      lastAddr  = 11'd0;
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "Ctl"}, {GNT1, GNT0, DONE1, DONE0, ERR1, ERR0, WR, RD, DOE, BUSY}, 0);
      checkOutput({tag, "Addr"}, ADDR, 0);
      checkOutput({tag, "Dout"}, DOUT, 0);
      checkOutput({tag, "Rdata"}, {RDATA1, RDATA0}, 0);
   endtask

   task automatic checkIdle();
      checkOutput("idleCtl", {GNT1, GNT0, DONE1, DONE0, WR, RD, DOE, BUSY}, 0);
      checkOutput("idleAddr", ADDR, lastAddr);
      checkOutput("idleRdata", {RDATA1, RDATA0}, {rdataM[1], rdataM[0]});
   endtask

   // One full transaction from the grant edge; ackDelay < 0 means ACK never rises.
   task automatic serveOne(input int ackDelay, input logic [7:0] din, input bit noise,
                           input int renew, input bit abortIt);
      int          w;
      int          renewNow;
      logic        weX;
      logic [10:0] aX;
      logic [7:0]  dX;
      logic [31:0] oneHot;
      w      = (reqM == 2'b11) ? (ptrM ? 0 : 1) : (reqM[0] ? 0 : 1);
      ptrM   = w[0];
      weX    = weM[w];
      aX     = addrM[w];
      dX     = wdataM[w];
      oneHot = (w == 0) ? 32'd1 : 32'd2;
      tick();
      lastGrant = GNT1;
      checkOutput("gnt", {GNT1, GNT0}, oneHot);
      checkOutput("gntBusy", BUSY, 1);
      checkOutput("gntAddr", ADDR, aX);
      checkOutput("gntDoe", DOE, weX);
      if (weX) checkOutput("gntDout", DOUT, dX);
      renewNow = (renew == 2) ? int'($urandom_range(0, 1)) : renew;
      if (renewNow != 0) randomRequest(w);
      else reqM[w] = 1'b0;
      for (int c = 2; c <= GAP; c++) begin
         ACK = noise && (c == 2);
         DIN = 8'($urandom);
         tick();
         checkOutput("gapGnt", {GNT1, GNT0}, 0);
         checkOutput("gapStrobe", {WR, RD}, 0);
         checkOutput("gapDone", {DONE1, DONE0}, 0);
         checkOutput("gapAddr", ADDR, aX);
         checkOutput("gapDoe", DOE, weX);
      end
      ACK = 1'b0;
      tick();
      checkOutput("strobeWr", WR, weX);
      checkOutput("strobeRd", RD, !weX);
      checkOutput("strobeAddr", ADDR, aX);
      checkOutput("strobeDoe", DOE, weX);
      if (ackDelay < 0) begin
`ifdef EEPROM_ARB_TIMEOUT_EN
         for (int i = 1; i < TMO; i++) begin
            DIN = 8'($urandom);
            tick();
            checkOutput("tmoWait", {DONE1, DONE0}, 0);
         end
         tick();
         checkOutput("tmoDone", {DONE1, DONE0}, oneHot);
         checkOutput("tmoErr", {ERR1, ERR0}, oneHot);
         checkOutput("tmoRdata", {RDATA1, RDATA0}, {rdataM[1], rdataM[0]});
         tick();
         checkOutput("tmoIdle", BUSY, 0);
         lastAddr = aX;
`else
         int busyCycles = 0;
         for (int i = 0; i < 1000; i++) begin
            tick();
            if (BUSY && !DONE0 && !DONE1) busyCycles++;
         end
         checkOutput("hangBusy", busyCycles, 1000);
         RESET = 1'b1;
         tick();
         RESET = 1'b0;
         checkAllZero("hangReset");
         resetModel();
`endif
         return;
      end
      for (int i = 0; i < ackDelay; i++) begin
         ACK = 1'b0;
         DIN = 8'($urandom);
         tick();
         checkOutput("waitDone", {DONE1, DONE0}, 0);
         checkOutput("waitStrobe", {WR, RD}, 0);
         checkOutput("waitBusy", BUSY, 1);
      end
      if (abortIt) begin
         RESET = 1'b1;
         tick();
         RESET = 1'b0;
         checkAllZero("abort");
         resetModel();
         return;
      end
      ACK = 1'b1;
      DIN = din;
      tick();
      if (!weX) rdataM[w] = din;
      checkOutput("done", {DONE1, DONE0}, oneHot);
      checkOutput("doneErr", {ERR1, ERR0}, 0);
      checkOutput("doneRdata", {RDATA1, RDATA0}, {rdataM[1], rdataM[0]});
      checkOutput("doneDoe", DOE, weX);
      checkOutput("doneBusy", BUSY, 1);
      DIN = 8'($urandom);
      tick();
      ACK = 1'b0;
      checkOutput("postBusy", BUSY, 0);
      checkOutput("postDone", {DONE1, DONE0}, 0);
      checkOutput("postDoe", DOE, 0);
      checkOutput("postAddr", ADDR, aX);
      lastAddr = aX;
   endtask

   initial begin
      RESET = 1'b1;
      ACK   = 1'b0;
      DIN   = 8'd0;
      reqM  = 2'b00;
      weM   = 2'b00;
      for (int p = 0; p < 2; p++) begin
         addrM[p]  = 11'd0;
         wdataM[p] = 8'd0;
      end
      resetModel();
      order = 4'd0;

      // Reset held with a pending request: nothing may be granted.
      applyStimulus(0, 1'b1, 11'h123, 8'hA5);
      for (int i = 0; i < 5; i++) begin
         tick();
         checkAllZero("reset");
      end
      RESET = 1'b0;
      serveOne(20, 8'h00, 1'b0, 0, 1'b0);

      tick();
      checkIdle();
      applyStimulus(1, 1'b0, 11'h7FF, 8'h00);
      serveOne(6, 8'h3C, 1'b1, 0, 1'b0);
      checkOutput("readRdata1", RDATA1, 8'h3C);

      // Continuous requests from both ports must alternate starting with port 0.
      randomRequest(0);
      randomRequest(1);
      for (int i = 0; i < 4; i++) begin
         serveOne(int'($urandom_range(1, 6)), 8'($urandom), 1'b1, 1, 1'b0);
         order = {order[2:0], lastGrant};
      end
      checkOutput("tieOrder", order, 4'b0101);

      for (int n = 0; n < 40; n++) begin
         int p;
         if (reqM == 2'b00) begin
            int idle = int'($urandom_range(0, 3));
            for (int i = 0; i < idle; i++) begin
               tick();
               checkIdle();
            end
            randomRequest(int'($urandom_range(0, 1)));
         end
         p = int'($urandom_range(0, 1));
         if (!reqM[p] && ($urandom_range(0, 2) == 0)) randomRequest(p);
         serveOne(int'($urandom_range(1, 12)), 8'($urandom), 1'($urandom_range(0, 1)), 2, 1'b0);
      end
      while (reqM != 2'b00) serveOne(int'($urandom_range(1, 5)), 8'($urandom), 1'b0, 0, 1'b0);

      // Abort during WAIT_ACK, then a fresh request must still complete.
      applyStimulus(1, 1'b0, 11'h2AA, 8'h00);
      serveOne(3, 8'h00, 1'b0, 0, 1'b1);
      applyStimulus(0, 1'b0, 11'h0F0, 8'h00);
      serveOne(4, 8'h5A, 1'b0, 0, 1'b0);
      checkOutput("afterAbortRdata0", RDATA0, 8'h5A);

      tick();
      checkIdle();
      applyStimulus(0, 1'b0, 11'h055, 8'h00);
      serveOne(-1, 8'h00, 1'b0, 0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
